urisc_mem_responder: RTL and testbench
======================================

// Module: urisc_mem_responder
// PURPOSE
//  Memory/IO responder on the URISC CPU bus: answers CSMR/RDMR/WRITE/ADDRESS/DATA_OUT
//  cycles with a single-port RAM, memory-mapped output FIFO and input port.
//  Owns CPU start-up: a byte-stream loader fills RAM from address 0, then raises RUN.
//  Sits between the CPU core and the testbench/host; one instance per CPU.
// PARAMETERS
//  AW          7      RAM address bits; RAM occupies 0 .. 2**AW-1
//  FIFO_DEPTH  4      output FIFO entries (power of two, >=2)
//  OUT_ADDR    8'h80  write: push FIFO; read: FIFO occupancy count
//  IN_ADDR     8'h81  read: in_data; writes ignored
// PORTS
//  clk_PH1   in   1     clock; all state updates on rising edge
//  rst_n     in   1     asynchronous active-low reset
//  CSMR      in   1     CPU chip select
//  RDMR      in   1     CPU read strobe
//  WRITE     in   1     CPU write strobe
//  ADDRESS   in   8     CPU address (changes on falling edge of clk_PH1)
//  DATA_OUT  in   8     CPU write data
//  DATA_IN   out  8     read data to CPU
//  RUN       out  1     CPU run enable
//  ld_start  in   1     begin load (pulse)
//  ld_len    in   AW+1  bytes to load, sampled with ld_start
//  ld_valid  in   1     loader byte valid
//  ld_data   in   8     loader byte
//  ld_ready  out  1     loader byte accepted when ld_valid&ld_ready
//  stop      in   1     abort load / halt CPU
//  out_valid out  1     FIFO non-empty
//  out_data  out  8     FIFO head
//  out_ready in   1     pop when out_valid&out_ready
//  in_data   in   8     external input port value
//  ovf       out  1     sticky: CPU write to OUT_ADDR while FIFO full
// BEHAVIOUR
//  Reset: state IDLE, RUN=0, ld_ready=0, FIFO empty, out_valid=0, ovf=0; RAM not cleared.
//  FSM IDLE/LOAD/RUN, registered; RUN=1 only in RUN, ld_ready=1 only in LOAD.
//   IDLE: ld_start -> latch len=min(ld_len,2**AW), cnt=0; len==0 -> RUN else -> LOAD.
//   LOAD: each handshake writes ram[cnt]=ld_data, cnt++; handshake with cnt==len-1 -> RUN.
//         stop -> IDLE (partial load kept). ld_start ignored.
//   RUN: stop -> IDLE. ld_start ignored. stop has priority over every other transition.
//  CPU write (RUN only; ignored in IDLE/LOAD): rising edge with CSMR&WRITE:
//   ADDRESS<2**AW -> ram[ADDRESS]=DATA_OUT; ==OUT_ADDR -> push DATA_OUT; other -> no effect.
//  CPU read: DATA_IN combinational from ADDRESS when CSMR&RDMR, else 8'h00:
//   RAM -> ram[ADDRESS]; OUT_ADDR -> zero-extended occupancy; IN_ADDR -> in_data; else 8'h00.
//   Combinational read needed: ADDRESS settles half a cycle before CPU samples.
//  FIFO: push when full dropped, ovf<=1 (clears only on reset). Pop and push same edge:
//   both happen (full stays full, no ovf; empty push then visible next cycle).
//   out_data = head, valid same cycle out_valid=1; pointers wrap modulo FIFO_DEPTH.
//  Loader byte and CPU write never coincide (exclusive states); single RAM write port.
//  Reset mid-operation: immediate return to reset values; RAM keeps contents.
// TESTING
//  ld_start,ld_len=3, bytes 11,22,33 -> ram[0..2]=11,22,33; RUN=1 cycle after 3rd handshake.
//  ld_len=0 -> RUN=1 next cycle, no RAM writes, ld_ready never 1.
//  RUN, CPU write 8'h5A to 8'h80 x5, out_ready=0, DEPTH=4 -> 4 entries, ovf=1, read 8'h80=4.
//  FIFO full, push 8'h77 with out_ready=1 same edge -> head popped, 8'h77 stored, ovf=0.
//  in_data=8'hC3, CSMR&RDMR ADDRESS=8'h81 -> DATA_IN=C3; ADDRESS=8'h90 -> DATA_IN=00.
//  stop mid-LOAD after 2 of 5 bytes -> IDLE, RUN=0; CPU write in IDLE leaves RAM unchanged.

Source files
------------

// File: rtl/urisc_mem_responder.sv
// urisc_mem_responder: RAM, output FIFO and input port on the URISC CPU bus.
// A byte-stream loader fills RAM from address 0 before the CPU is allowed to run;
// CPU writes are honoured only while running, reads are answered combinationally.
module urisc_mem_responder #(
  parameter int         AW         = 7,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] OUT_ADDR   = 8'h80,
  parameter logic [7:0] IN_ADDR    = 8'h81
) (
  input  logic          clk_PH1,
  input  logic          rst_n,
  input  logic          CSMR,
  input  logic          RDMR,
  input  logic          WRITE,
  input  logic [7:0]    ADDRESS,
  input  logic [7:0]    DATA_OUT,
  output logic [7:0]    DATA_IN,
  output logic          RUN,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic          stop,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  input  logic [7:0]    in_data,
  output logic          ovf
);

  localparam int          RAM_N   = 2**AW;
  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] RAM_N_L = {1'b1, {AW{1'b0}}};
  localparam logic [PW:0] DEPTH_L = {1'b1, {PW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t        state, state_nx;
  logic [AW:0]   len, len_nx;
  logic [AW:0]   cnt, cnt_nx;

  logic [7:0]    ram [RAM_N];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;

  logic          ld_we, cpu_wr, ram_we;
  logic [AW-1:0] ram_wa;
  logic [7:0]    ram_wd;
  logic          full, push_req, push, pop;

  // Load length saturates at the RAM size so the loader can never wrap onto itself.
  function automatic logic [AW:0] sat_len(input logic [AW:0] n);
    return (n > RAM_N_L) ? RAM_N_L : n;
  endfunction

  // True when the bus address falls inside the RAM window.
  function automatic logic in_ram(input logic [7:0] a);
    return (a >> AW) == 8'd0;
  endfunction

  // State register plus load length / byte counter.
  always_ff @(posedge clk_PH1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      len   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      len   <= len_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; stop overrides every other transition.
  always_comb begin
    state_nx = state;
    len_nx   = len;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (!stop && ld_start) begin
          len_nx   = sat_len(ld_len);
          cnt_nx   = '0;
          state_nx = (sat_len(ld_len) == '0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_valid) cnt_nx = cnt + 1'b1;
        if (stop)                                    state_nx = S_IDLE;
        else if (ld_valid && (cnt == len - 1'b1))    state_nx = S_RUN;
      end
      S_RUN: begin
        if (stop) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    RUN      = (state == S_RUN);
    ld_ready = (state == S_LOAD);
  end

  // Single RAM write port shared by loader (LOAD) and CPU (RUN); the states are exclusive.
  always_comb begin
    ld_we    = (state == S_LOAD) && ld_valid;
    cpu_wr   = (state == S_RUN) && CSMR && WRITE;
    ram_we   = ld_we || (cpu_wr && in_ram(ADDRESS));
    ram_wa   = ld_we ? cnt[AW-1:0] : ADDRESS[AW-1:0];
    ram_wd   = ld_we ? ld_data : DATA_OUT;
    full     = (count == DEPTH_L);
    pop      = out_valid && out_ready;
    push_req = cpu_wr && (ADDRESS == OUT_ADDR);
    push     = push_req && (!full || pop);
  end

  // RAM storage: no reset, contents survive rst_n.
  always_ff @(posedge clk_PH1) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  // FIFO storage: written at the tail on an accepted push.
  always_ff @(posedge clk_PH1) begin
    if (push) fifo_mem[wptr] <= DATA_OUT;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_PH1 or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) ovf <= 1'b1;
    end
  end

  // FIFO head is presented directly.
  always_comb begin
    out_valid = (count != '0);
    out_data  = fifo_mem[rptr];
  end

  // Combinational read mux: the address settles half a cycle before the CPU samples.
  always_comb begin
    DATA_IN = 8'h00;
    if (CSMR && RDMR) begin
      if (in_ram(ADDRESS))          DATA_IN = ram[ADDRESS[AW-1:0]];
      else if (ADDRESS == OUT_ADDR) DATA_IN = 8'(count);
      else if (ADDRESS == IN_ADDR)  DATA_IN = in_data;
    end
  end

endmodule

// File: tb/tb_urisc_mem_responder.sv
// Bench for urisc_mem_responder: directed scenarios plus randomized bus traffic,
// checked against a queue/array reference model through a decoupled monitor.
module tb_urisc_mem_responder;

  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int RAM_N = 128;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic        clk_PH1 = 1'b0;
  logic        rst_n;
  logic        CSMR, RDMR, WRITE;
  logic [7:0]  ADDRESS, DATA_OUT, DATA_IN;
  logic        RUN;
  logic        ld_start;
  logic [AW:0] ld_len;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        stop;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [7:0]  in_data;
  logic        ovf;

  always #5 clk_PH1 = ~clk_PH1;

  urisc_mem_responder #(
    .AW(AW), .FIFO_DEPTH(DEPTH), .OUT_ADDR(8'h80), .IN_ADDR(8'h81)
  ) dut (
    .clk_PH1(clk_PH1), .rst_n(rst_n), .CSMR(CSMR), .RDMR(RDMR), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .RUN(RUN),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .stop(stop), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .in_data(in_data), .ovf(ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mram [RAM_N];
  bit         mknown [RAM_N];
  int         m_mode = M_IDLE;
  int         m_len = 0;
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;
  logic [7:0] mq [$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] val;
    bit         known;
  } rd_t;
  rd_t rq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 4)      return 8'($urandom_range(0, RAM_N - 1));
    else if (r <= 6) return 8'h80;
    else if (r == 7) return 8'h81;
    else             return 8'($urandom);
  endfunction

  task automatic bus_idle();
    CSMR = 1'b0; RDMR = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; DATA_OUT = 8'h00;
    ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = 8'h00; stop = 1'b0;
  endtask

  // Apply the spec rules to the inputs currently driven, before the clock edge.
  task automatic commit();
    rd_t r;
    bit  pop;
    if (CSMR && RDMR) begin
      r.addr  = ADDRESS;
      r.known = 1'b1;
      if (ADDRESS < RAM_N) begin
        r.val   = mram[ADDRESS[6:0]];
        r.known = mknown[ADDRESS[6:0]];
      end else if (ADDRESS == 8'h80) r.val = 8'(mq.size());
      else if (ADDRESS == 8'h81)     r.val = in_data;
      else                           r.val = 8'h00;
      rq.push_back(r);
    end
    pop = out_ready && (mq.size() > 0);
    case (m_mode)
      M_IDLE: begin
        if (!stop && ld_start) begin
          m_len  = (int'(ld_len) > RAM_N) ? RAM_N : int'(ld_len);
          m_cnt  = 0;
          m_mode = (m_len == 0) ? M_RUN : M_LOAD;
        end
      end
      M_LOAD: begin
        if (ld_valid) begin
          mram[m_cnt]   = ld_data;
          mknown[m_cnt] = 1'b1;
          m_cnt++;
        end
        if (stop)                           m_mode = M_IDLE;
        else if (ld_valid && m_cnt == m_len) m_mode = M_RUN;
      end
      default: begin
        if (CSMR && WRITE) begin
          if (ADDRESS < RAM_N) begin
            mram[ADDRESS[6:0]]   = DATA_OUT;
            mknown[ADDRESS[6:0]] = 1'b1;
          end else if (ADDRESS == 8'h80) begin
            if (mq.size() < DEPTH || pop) mq.push_back(DATA_OUT);
            else                          m_ovf = 1'b1;
          end
        end
        if (stop) m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic cycle();
    commit();
    @(negedge clk_PH1); #1;
    chk("run", 32'(RUN), 32'(m_mode == M_RUN));
    chk("ld_ready", 32'(ld_ready), 32'(m_mode == M_LOAD));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    bus_idle(); CSMR = 1'b1; WRITE = 1'b1; ADDRESS = a; DATA_OUT = d;
    cycle();
  endtask

  task automatic cpu_read(input logic [7:0] a);
    bus_idle(); CSMR = 1'b1; RDMR = 1'b1; ADDRESS = a;
    cycle();
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 1'b0;
    #1;
    chk("rst_run", 32'(RUN), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    mq.delete();
    m_mode = M_IDLE;
    m_ovf  = 1'b0;
    @(negedge clk_PH1); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a FIFO pop or a read.
  initial begin
    logic [7:0] e;
    rd_t        r;
    forever begin
      @(negedge clk_PH1); #3;
      if (rst_n && out_valid && out_ready) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL fifo_pop: got %0h expected no data", out_data);
        end else begin
          e = mq.pop_front();
          chk("fifo_data", 32'(out_data), 32'(e));
        end
      end
      if (CSMR && RDMR) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_sb: got %0h expected no read", DATA_IN);
        end else begin
          r = rq.pop_front();
          if (r.known) chk($sformatf("read_%02h", r.addr), 32'(DATA_IN), 32'(r.val));
        end
      end
    end
  end

  initial begin
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    bus_idle();
    out_ready = 1'b0;
    in_data   = 8'h00;
    rst_n     = 1'b0;
    @(negedge clk_PH1); #1;
    chk("reset_run", 32'(RUN), 32'd0);
    chk("reset_ld_ready", 32'(ld_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // Three-byte load, RUN one cycle after the third handshake
    bus_idle(); ld_start = 1'b1; ld_len = 8'd3; cycle();
    for (int i = 0; i < 3; i++) begin
      bus_idle(); ld_valid = 1'b1; ld_data = vals[i]; cycle();
    end
    for (int i = 0; i < 3; i++) cpu_read(8'(i));

    // Input port, unmapped address, and read strobe gating
    in_data = 8'hC3;
    cpu_read(8'h81);
    cpu_read(8'h90);
    bus_idle(); CSMR = 1'b1; ADDRESS = 8'h81; #1;
    chk("no_rdmr", 32'(DATA_IN), 32'd0);
    cycle();

    // Overflow: five pushes into a four-entry FIFO, then occupancy readback
    out_ready = 1'b0;
    repeat (5) cpu_write(8'h80, 8'h5A);
    cpu_read(8'h80);

    // Full FIFO: push and pop on the same edge, then drain
    out_ready = 1'b1;
    cpu_write(8'h80, 8'h77);
    repeat (5) begin bus_idle(); cycle(); end
    out_ready = 1'b0;

    // ld_start ignored while running, then stop and an ignored write in IDLE
    bus_idle(); ld_start = 1'b1; ld_len = 8'd5; cycle();
    bus_idle(); stop = 1'b1; cycle();
    cpu_write(8'h00, 8'hEE);
    cpu_read(8'h00);

    // Zero-length load goes straight to RUN
    bus_idle(); ld_start = 1'b1; ld_len = 8'd0; cycle();
    bus_idle(); stop = 1'b1; cycle();

    // Load of 5 aborted after 2 bytes
    bus_idle(); ld_start = 1'b1; ld_len = 8'd5; cycle();
    bus_idle(); ld_valid = 1'b1; ld_data = 8'hAA; cycle();
    bus_idle(); ld_valid = 1'b1; ld_data = 8'hBB; cycle();
    bus_idle(); stop = 1'b1; cycle();
    cpu_write(8'h03, 8'h99);
    for (int i = 0; i < 5; i++) cpu_read(8'(i));

    // Oversized load saturates at the RAM size; bus noise and ld_start ignored
    bus_idle(); ld_start = 1'b1; ld_len = 8'd200; cycle();
    for (int i = 0; i < 600 && m_mode == M_LOAD; i++) begin
      bus_idle();
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = 8'($urandom);
      ld_start = ($urandom_range(0, 7) == 0);
      ld_len   = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin CSMR = 1'b1; WRITE = 1'b1; ADDRESS = rand_addr(); DATA_OUT = 8'($urandom); end
        1: begin CSMR = 1'b1; RDMR = 1'b1; ADDRESS = rand_addr(); end
        default: ;
      endcase
      cycle();
    end
    chk("sat_load_run", 32'(RUN), 32'd1);
    chk("sat_load_count", 32'(m_cnt), 32'(RAM_N));

    // Randomized CPU traffic while running
    for (int i = 0; i < 400; i++) begin
      bus_idle();
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1: begin CSMR = 1'b1; WRITE = 1'b1; ADDRESS = rand_addr(); DATA_OUT = 8'($urandom); end
        2, 3: begin CSMR = 1'b1; RDMR = 1'b1; ADDRESS = rand_addr(); end
        4:    begin WRITE = 1'b1; ADDRESS = rand_addr(); DATA_OUT = 8'($urandom); end
        default: ;
      endcase
      cycle();
    end

    // Reset mid-operation with FIFO data pending; RAM must survive
    out_ready = 1'b0;
    cpu_write(8'h80, 8'h01);
    cpu_write(8'h80, 8'h02);
    do_reset();
    cpu_read(8'h00);
    cpu_read(8'h05);
    cpu_read(8'h7F);
    cpu_read(8'h80);
    bus_idle(); cycle();
    bus_idle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
